// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-requester round-robin arbiter that drives the select
// line of a 2:1 mux (requester 0 -> i0, requester 1 -> i1).
// All outputs are registered. Grants are one-hot or idle, never both.
// Optional feature: define ARB_TIMEOUT_EN to force a hand-over once the owner
// has held the path for HOLD_MAX cycles while the other side waits.
module mux_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic done0,
    input  logic done1,
    output logic gnt0,
    output logic gnt1,
    output logic select,
    output logic busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StG0   = 2'd1,
        StG1   = 2'd2
    } state_e;

    // Reject parameter sets where the timeout could never be reached.
    if ((HOLD_MAX < 1) || (HOLD_MAX > (2 ** CNT_W) - 1)) begin : g_hold_max_check
        $error("mux_sel_arbiter: HOLD_MAX must be in 1..2**CNT_W-1");
    end

    state_e r_state;
    state_e w_state_d;
    logic   r_last;
    logic   r_gnt0;
    logic   r_gnt1;
    logic   r_select;
    logic   r_busy;

    // Forced hand-over requests (only ever set with the timeout feature).
    logic   w_timeout0;
    logic   w_timeout1;
    // Owner gives up the path this edge.
    logic   w_release0;
    logic   w_release1;
    logic   w_enter_g0;
    logic   w_enter_g1;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HoldSat  = '1;

    logic [CNT_W-1:0] r_hold_cnt;

    // Timeout fires when the owner has already been held HOLD_MAX-1 cycles
    // with the other side waiting, and the other side is still waiting now.
    always_comb begin
        w_timeout0 = (r_state == StG0) && req1 && (r_hold_cnt == HoldLast);
        w_timeout1 = (r_state == StG1) && req0 && (r_hold_cnt == HoldLast);
    end

    // Hold counter: cleared on any state change, counts contended cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (w_state_d != r_state) begin
            r_hold_cnt <= '0;
        end else if (((r_state == StG0) && req1) || ((r_state == StG1) && req0)) begin
            if (r_hold_cnt != HoldSat) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end
`else
    // No forced hand-over; a grant lasts until its owner releases it.
    always_comb begin
        w_timeout0 = 1'b0;
        w_timeout1 = 1'b0;
    end
`endif

    // Release decode: explicit done, dropped request, or forced timeout.
    always_comb begin
        w_release0 = done0 || !req0 || w_timeout0;
        w_release1 = done1 || !req1 || w_timeout1;
    end

    // Next-state: round-robin in idle, direct hand-over on release.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (req0 && req1) begin
                    w_state_d = r_last ? StG0 : StG1;
                end else if (req0) begin
                    w_state_d = StG0;
                end else if (req1) begin
                    w_state_d = StG1;
                end
            end
            StG0: begin
                if (w_release0) begin
                    w_state_d = req1 ? StG1 : StIdle;
                end
            end
            StG1: begin
                if (w_release1) begin
                    w_state_d = req0 ? StG0 : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Entry strobes drive last-winner and the mux select.
    always_comb begin
        w_enter_g0 = (w_state_d == StG0) && (r_state != StG0);
        w_enter_g1 = (w_state_d == StG1) && (r_state != StG1);
    end

    // State and registered outputs; select keeps its value through idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_select <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_gnt0  <= (w_state_d == StG0);
            r_gnt1  <= (w_state_d == StG1);
            r_busy  <= (w_state_d != StIdle);
            if (w_enter_g0) begin
                r_last   <= 1'b0;
                r_select <= 1'b0;
            end else if (w_enter_g1) begin
                r_last   <= 1'b1;
                r_select <= 1'b1;
            end
        end
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign select = r_select;
    assign busy   = r_busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed vector table, hand-written
// hold/timeout sequence, and randomized traffic against a behavioural model.
module tb_mux_sel_arbiter;

    localparam int unsigned HoldMax = 8;
    localparam int unsigned CntW    = 4;
    localparam int          NVec    = 20;

    logic clk = 1'b0;
    logic reset, req0, req1, done0, done1;
    logic gnt0, gnt1, select, busy;

    int n_pass  = 0;
    int n_total = 0;

    mux_sel_arbiter #(
        .HOLD_MAX(HoldMax),
        .CNT_W   (CntW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .done0 (done0),
        .done1 (done1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .select(select),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic r0;
        logic r1;
        logic d0;
        logic d1;
        logic g0;
        logic g1;
        logic sel;
        logic bsy;
    } vec_t;

    vec_t vecs[NVec];

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic g0, input logic g1,
                             input logic sel, input logic bsy);
        check({tag, " gnt0"}, gnt0, g0);
        check({tag, " gnt1"}, gnt1, g1);
        check({tag, " select"}, select, sel);
        check({tag, " busy"}, busy, bsy);
    endtask

    // Drive inputs, take one rising edge, settle past it.
    task automatic cycle(input logic rst, input logic r0, input logic r1,
                         input logic d0, input logic d1);
        reset = rst; req0 = r0; req1 = r1; done0 = d0; done1 = d1;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: owner is 0, 1, or 2 (nobody).
    int   m_owner;
    int   m_last;
    int   m_sel;
    int   m_wait;

    task automatic model_step(input logic rst, input logic r0, input logic r1,
                              input logic d0, input logic d1);
        int   nxt;
        int   k;
        logic req[2];
        logic dn[2];
        logic rel;
        req[0] = r0; req[1] = r1; dn[0] = d0; dn[1] = d1;
        if (rst) begin
            m_owner = 2; m_last = 1; m_sel = 0; m_wait = 0;
            return;
        end
        if (m_owner == 2) begin
            if (r0 && r1) nxt = 1 - m_last;
            else if (r0) nxt = 0;
            else if (r1) nxt = 1;
            else nxt = 2;
        end else begin
            k = m_owner;
            rel = dn[k] || !req[k];
`ifdef ARB_TIMEOUT_EN
            if (req[1-k] && (m_wait == int'(HoldMax) - 1)) rel = 1'b1;
`endif
            if (rel) nxt = req[1-k] ? 1 - k : 2;
            else nxt = k;
        end
        if (nxt != m_owner) m_wait = 0;
        else if (nxt != 2 && req[1-nxt] && m_wait < 15) m_wait++;
        if (nxt != 2 && nxt != m_owner) begin
            m_last = nxt;
            m_sel  = nxt;
        end
        m_owner = nxt;
    endtask

    initial begin
        logic held;
        int   held_cycles;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;

        // rst r0 r1 d0 d1 | g0 g1 sel busy
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        @(negedge clk);
        for (int i = 0; i < NVec; i++) begin
            cycle(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
            check_all($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].sel,
                      vecs[i].bsy);
        end

        // Long hold: req0 owns the path while req1 waits.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("hold_start", 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        held = 1'b1;
        for (int c = 1; c < int'(HoldMax); c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (!gnt0 || gnt1) held = 1'b0;
        end
        check("timeout_before_limit", held, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("timeout_switch", 1'b0, 1'b1, 1'b1, 1'b1);
`else
        held_cycles = 0;
        for (int c = 0; c < 50; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (gnt0 && !gnt1) held_cycles++;
        end
        check("no_timeout_held50", held_cycles == 50, 1'b1);
        check_all("no_timeout_end", 1'b1, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic rst, r0, r1, d0, d1;
            rst = (c == 0) || ($urandom_range(63) == 0);
            r0  = ($urandom_range(3) != 0);
            r1  = ($urandom_range(3) != 0);
            d0  = ($urandom_range(3) == 0);
            d1  = ($urandom_range(3) == 0);
            model_step(rst, r0, r1, d0, d1);
            cycle(rst, r0, r1, d0, d1);
            check_all($sformatf("rand%0d", c), m_owner == 0, m_owner == 1, m_sel[0],
                      m_owner != 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
